modular_double_seq: RTL

- Sequential modular doubler over the BLS12-381 scalar field, the inverse direction of the combinational halving stage.
- Computes y = x·2^k mod M by k iterated doublings, one per clock.
- Used to encode operands into Montgomery form ahead of the poly-mul datapath (k = 256 gives x·R mod M).
- Loading uses a valid/ready handshake; result delivery uses a valid/ready handshake.

---
 rtl/modular_double_seq_pkg.sv | 37 +++
 rtl/modular_double_seq_if.sv | 33 +++
 rtl/modular_double_seq_mod_dbl.sv | 31 +++
 rtl/modular_double_seq.sv | 118 +++++++++++
 4 files changed

// File: rtl/modular_double_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package   : modular_double_seq_pkg
// Purpose   : Shared BLS12-381 scalar-field constants and the state encoding
//             used by the sequential modular doubler. The field modulus is
//             defined only here so that every arithmetic block agrees on it.
// Contents  : DATA_WIDTH, K_WIDTH, FR_MODULUS, FR_MODULUS_HALF, FR_TWO_M,
//             FR_R, state_e
// Revision  : 1.0 - initial release
// ============================================================================
package modular_double_seq_pkg;

  localparam int DATA_WIDTH = 256;
  localparam int K_WIDTH    = 9;

  // r = 0x73eda753...00000001 (BLS12-381 scalar field order)
  localparam logic [DATA_WIDTH-1:0] FR_MODULUS =
    256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

  // (M+1)/2, the modular inverse of 2; M is odd so this is (M>>1)+1
  localparam logic [DATA_WIDTH-1:0] FR_MODULUS_HALF = (FR_MODULUS >> 1) + 256'd1;

  // 2M still fits in DATA_WIDTH bits because M < 2^255
  localparam logic [DATA_WIDTH-1:0] FR_TWO_M = FR_MODULUS << 1;

  // Montgomery radix R = 2^256 mod M
  localparam logic [DATA_WIDTH-1:0] FR_R =
    256'h1824b159acc5056f998c4fefecbc4ff55884b7fa0003480200000001fffffffe;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : modular_double_seq_pkg
`default_nettype wire

// File: rtl/modular_double_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : modular_double_seq_if
// Purpose   : Load and result handshakes of the modular doubler.
// Signals   : in_valid/in_ready/x_in/k_in   - operand load handshake
//             out_valid/out_ready/y_out/range_err - result handshake
// Modports  : master - producer/consumer side (drives operands, out_ready)
//             slave  - the doubler itself
// Revision  : 1.0 - initial release
// ============================================================================
interface modular_double_seq_if;

  logic                                            in_valid;
  logic                                            in_ready;
  logic [modular_double_seq_pkg::DATA_WIDTH-1:0]   x_in;
  logic [modular_double_seq_pkg::K_WIDTH-1:0]      k_in;
  logic                                            out_valid;
  logic                                            out_ready;
  logic [modular_double_seq_pkg::DATA_WIDTH-1:0]   y_out;
  logic                                            range_err;

  modport master (
    output in_valid, x_in, k_in, out_ready,
    input  in_ready, out_valid, y_out, range_err
  );

  modport slave (
    input  in_valid, x_in, k_in, out_ready,
    output in_ready, out_valid, y_out, range_err
  );

endinterface : modular_double_seq_if
`default_nettype wire

// File: rtl/modular_double_seq_mod_dbl.sv
`default_nettype none
// ============================================================================
// Module    : mod_dbl
// Purpose   : Combinational single modular doubling, y = 2a mod M, for a < M.
// Ports     : a - input residue (must be < M)
//             y - 2a mod M, fully reduced
// Revision  : 1.0 - initial release
// ============================================================================
module mod_dbl
  import modular_double_seq_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] y
);

  // 2a is a (DATA_WIDTH+1)-bit value {carry, t_lo}. The compare against M
  // includes the carry so the block stays correct for any modulus width.
  logic                  t_carry;
  logic [DATA_WIDTH-1:0] t_lo;
  logic                  t_ge_m;

  assign t_carry = a[DATA_WIDTH-1];
  assign t_lo    = {a[DATA_WIDTH-2:0], 1'b0};
  assign t_ge_m  = t_carry | (t_lo >= FR_MODULUS);

  // When t >= M the true difference is < M < 2^DATA_WIDTH, so the low
  // DATA_WIDTH bits of the wrapped subtraction are exact.
  assign y = t_ge_m ? (t_lo - FR_MODULUS) : t_lo;

endmodule : mod_dbl
`default_nettype wire

// File: rtl/modular_double_seq.sv
`default_nettype none
// ============================================================================
// Module    : modular_double_seq
// Purpose   : Sequential modular doubler, y = x * 2^k mod M, one doubling per
//             clock. With k = 256 it converts x into Montgomery form.
// Ports     : clk - clock, rising edge
//             rst - asynchronous active-high reset
//             bus - modular_double_seq_if.slave
//                   in_valid/in_ready, x_in, k_in : operand load
//                   out_valid/out_ready, y_out, range_err : result delivery
// Revision  : 1.0 - initial release
// ============================================================================
module modular_double_seq
  import modular_double_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  modular_double_seq_if.slave   bus
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [K_WIDTH-1:0]    cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] y_out_q, y_out_d;
  logic                  range_err_q, range_err_d;

  // Load-cycle reduction. Any 256-bit x is < 3M, so at most one of the
  // two subtractions is needed to land below M.
  logic                  x_ge_m;
  logic                  x_ge_2m;
  logic [DATA_WIDTH-1:0] x_reduced;

  assign x_ge_m    = (bus.x_in >= FR_MODULUS);
  assign x_ge_2m   = (bus.x_in >= FR_TWO_M);
  assign x_reduced = x_ge_2m ? (bus.x_in - FR_TWO_M) :
                     x_ge_m  ? (bus.x_in - FR_MODULUS) :
                               bus.x_in;

  logic [DATA_WIDTH-1:0] acc_dbl;

  mod_dbl u_mod_dbl (
    .a (acc_q),
    .y (acc_dbl)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          acc_d   = x_reduced;
          err_d   = x_ge_m;
          cnt_d   = bus.k_in;
          state_d = (bus.k_in != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        acc_d = acc_dbl;
        cnt_d = cnt_q - K_WIDTH'(1);
        if (cnt_q == K_WIDTH'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered and
    // line up exactly with the state they describe.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    y_out_d     = (state_d == ST_DONE) ? acc_d : '0;
    range_err_d = (state_d == ST_DONE) & err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_out_q     <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      y_out_q     <= y_out_d;
      range_err_q <= range_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y_out     = y_out_q;
  assign bus.range_err = range_err_q;

endmodule : modular_double_seq
`default_nettype wire
